multdiv_ctrl: RTL and testbench
===============================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of multiply/divide step cycles per operation.
REQ-002 SHALL have parameter CNT_W, default 6, meaning the width of the iteration counter (2^CNT_W > ITER).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces IDLE and clears all state.
REQ-005 ctrl_MULT  input  1  start-multiply pulse, sampled only in IDLE.
REQ-006 ctrl_DIV  input  1  start-divide pulse, sampled only in IDLE.
REQ-007 booth_bits  input  2  product register {bit0, extra bit}, used for Booth recoding.
REQ-008 rem_neg  input  1  sign of the trial partial remainder from the datapath ALU.
REQ-009 divisor_zero  input  1  divisor operand equals zero.
REQ-010 dividend_neg, divisor_neg  input  1 each  operand signs, latched in INIT.
REQ-011 init_load  output  1  selects the operand-load path into the 65-bit product/remainder register.
REQ-012 reg_we  output  1  write enable of the product/remainder register.
REQ-013 alu_op  output  2  00 NONE, 01 ADD, 10 SUB.
REQ-014 shift_left  output  1  1 = divide left shift, 0 = multiply arithmetic right shift.
REQ-015 restore  output  1  writeback keeps the pre-subtract remainder.
REQ-016 q_bit  output  1  quotient bit inserted this cycle.
REQ-017 negate_q  output  1  datapath negates the quotient at writeback.
REQ-018 busy, data_resultRDY, data_exception  output  1 each  status outputs.

Function
REQ-019 SHALL implement the states IDLE, INIT, MSTEP, DSTEP and DONE.
REQ-020 IDLE: on ctrl_MULT, latch op=MULT and go to INIT; on ctrl_DIV, latch op=DIV and go to INIT; if both are high, MULT wins.
REQ-021 Start pulses outside IDLE SHALL be ignored with no effect.
REQ-022 INIT (one cycle): init_load=1, reg_we=1, counter=0, latch operand signs.
REQ-023 INIT next state: MULT goes to MSTEP; DIV with divisor_zero=0 goes to DSTEP; DIV with divisor_zero=1 goes to DONE with the exception flag set.
REQ-024 MSTEP: reg_we=1, shift_left=0; alu_op = ADD for booth_bits 01, SUB for 10, NONE for 00/11.
REQ-025 DSTEP: reg_we=1, shift_left=1, alu_op=SUB, restore=rem_neg, q_bit=~rem_neg.
REQ-026 Counter SHALL increment every MSTEP/DSTEP cycle; the step cycle where counter==ITER-1 SHALL be the last, and the FSM then goes to DONE.
REQ-027 DONE (one cycle): data_resultRDY=1; data_exception=latched flag; negate_q=(dividend_neg^divisor_neg) for DIV without exception, else 0; next state IDLE.
REQ-028 busy=1 in INIT, MSTEP, DSTEP and DONE; busy=0 in IDLE.
REQ-029 Latency: a start sampled at edge 0 gives data_resultRDY high for the cycle after edge ITER+2 (34 for the default); divide-by-zero gives edge 2.
REQ-030 Outputs not named active for the current state SHALL be 0; all outputs SHALL be Moore outputs except alu_op, restore and q_bit, which are combinational from the step inputs.
REQ-031 Minimum start-to-start spacing SHALL be ITER+3 cycles (one IDLE cycle after DONE).

Reset
REQ-032 Reset asserted at any time, including mid-operation, SHALL immediately set state=IDLE, counter=0, op, flag and latched signs=0, and drive every output to 0.
REQ-033 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-034 Shared package multdiv_pkg SHALL hold the state encoding, the alu_op encodings (NONE/ADD/SUB) and the ITER default.
REQ-035 State, counter and latched flags SHALL be stored in the team's register module (dffe_ref cells, clr=reset).
REQ-036 Sub-module iter_counter (CNT_W-bit, synchronous clear plus enable, asynchronous reset) SHALL provide the iteration count and a terminal flag.

Verification
REQ-037 Multiply 7 x -3, booth_bits driven by a reference model: 32 MSTEP cycles, resultRDY at cycle 34, alu_op sequence matches the Booth table.
REQ-038 Divide with divisor_zero=1: INIT then DONE, resultRDY=1 and data_exception=1 at cycle 2, no DSTEP cycles.
REQ-039 Divide -20 / 3 with the model driving rem_neg: 32 DSTEP cycles, restore==rem_neg and q_bit==~rem_neg every cycle, negate_q=1 in DONE.
REQ-040 ctrl_MULT and ctrl_DIV both high in IDLE: MSTEP path taken; a ctrl_DIV pulse at step 10 is ignored and the cycle count is unchanged.
REQ-041 Reset pulsed at DSTEP step 15: all outputs 0 immediately; a new ctrl_MULT after release completes in 34 cycles.
REQ-042 Back-to-back operations: a start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide controller:
// state encoding, ALU op encodings and the default step count.
package multdiv_pkg;

   localparam int ITER_DEF = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      MSTEP = 3'd2,
      DSTEP = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ALU_NONE = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10
   } aluOp_t;

   // Radix-2 Booth recoding of {bit0, extra bit}
   function automatic aluOp_t boothOp(input logic [1:0] bits);
      case (bits)
         2'b01:   return ALU_ADD;
         2'b10:   return ALU_SUB;
         default: return ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/dffe_ref.sv
// Register cell with enable and asynchronous active-high clear.
module dffe_ref #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/multdiv_ctrl_iter_counter.sv
// Step counter: synchronous clear wins over enable; flags the last step.
module iter_counter #(
   parameter int CNT_W = 6,
   parameter int ITER  = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic last
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countNext;

   assign countNext = clr ? '0 : count + CNT_W'(1);
   assign last      = (count == CNT_W'(ITER - 1));

   dffe_ref #(.W(CNT_W)) uCnt (
      .clk (clk),
      .clr (reset),
      .en  (clr | en),
      .d   (countNext),
      .q   (count)
   );

endmodule

// File: rtl/multdiv_ctrl.sv
// Control FSM for a shared iterative Booth multiplier / restoring divider.
// Moore outputs except alu_op, restore and q_bit, which follow the step inputs.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int ITER  = ITER_DEF,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ctrl_MULT,
   input  logic       ctrl_DIV,
   input  logic [1:0] booth_bits,
   input  logic       rem_neg,
   input  logic       divisor_zero,
   input  logic       dividend_neg,
   input  logic       divisor_neg,
   output logic       init_load,
   output logic       reg_we,
   output logic [1:0] alu_op,
   output logic       shift_left,
   output logic       restore,
   output logic       q_bit,
   output logic       negate_q,
   output logic       busy,
   output logic       data_resultRDY,
   output logic       data_exception
);

   logic [2:0] stateQ;
   state_t     state, stateNext;
   logic       opDiv;
   logic       excFlag, dvdNeg, dvsNeg;
   logic       stepLast;
   logic       isIdle, isInit, isStep;

   assign state  = state_t'(stateQ);
   assign isIdle = (state == IDLE);
   assign isInit = (state == INIT);
   assign isStep = (state == MSTEP) || (state == DSTEP);

   dffe_ref #(.W(3)) uState (
      .clk (clk), .clr (reset), .en (1'b1), .d (stateNext), .q (stateQ)
   );

   // MULT has priority, so the op is DIV only when MULT is low
   dffe_ref #(.W(1)) uOp (
      .clk (clk), .clr (reset), .en (isIdle & (ctrl_MULT | ctrl_DIV)),
      .d (~ctrl_MULT), .q (opDiv)
   );

   dffe_ref #(.W(3)) uFlags (
      .clk (clk), .clr (reset), .en (isInit),
      .d   ({opDiv & divisor_zero, dividend_neg, divisor_neg}),
      .q   ({excFlag, dvdNeg, dvsNeg})
   );

   iter_counter #(.CNT_W(CNT_W), .ITER(ITER)) uIter (
      .clk (clk), .reset (reset), .clr (isInit), .en (isStep), .last (stepLast)
   );

   always_comb begin
      stateNext      = state;
      init_load      = 1'b0;
      reg_we         = 1'b0;
      alu_op         = ALU_NONE;
      shift_left     = 1'b0;
      restore        = 1'b0;
      q_bit          = 1'b0;
      negate_q       = 1'b0;
      busy           = 1'b1;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (ctrl_MULT | ctrl_DIV) stateNext = INIT;
         end
         INIT: begin
            init_load = 1'b1;
            reg_we    = 1'b1;
            if (!opDiv)            stateNext = MSTEP;
            else if (divisor_zero) stateNext = DONE;
            else                   stateNext = DSTEP;
         end
         MSTEP: begin
            reg_we = 1'b1;
            alu_op = boothOp(booth_bits);
            if (stepLast) stateNext = DONE;
         end
         DSTEP: begin
            reg_we     = 1'b1;
            shift_left = 1'b1;
            alu_op     = ALU_SUB;
            restore    = rem_neg;
            q_bit      = ~rem_neg;
            if (stepLast) stateNext = DONE;
         end
         DONE: begin
            data_resultRDY = 1'b1;
            data_exception = excFlag;
            negate_q       = opDiv & ~excFlag & (dvdNeg ^ dvsNeg);
            stateNext      = IDLE;
         end
         default: begin
            busy      = 1'b0;
            stateNext = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench: offset-based behavioural model of the operation
// timeline plus Booth / restoring-division datapath models driving the DUT.
module tb_multdiv_ctrl;
   import multdiv_pkg::*;

   localparam int ITER = 32;

   logic       clk = 1'b0, reset = 1'b1;
   logic       ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [1:0] booth_bits = 2'b00;
   logic       rem_neg = 1'b0, divisor_zero = 1'b0;
   logic       dividend_neg = 1'b0, divisor_neg = 1'b0;
   logic       init_load, reg_we, shift_left, restore, q_bit, negate_q;
   logic       busy, data_resultRDY, data_exception;
   logic [1:0] alu_op;

   multdiv_ctrl #(.ITER(ITER), .CNT_W(6)) dut (
      .clk (clk), .reset (reset), .ctrl_MULT (ctrl_MULT), .ctrl_DIV (ctrl_DIV),
      .booth_bits (booth_bits), .rem_neg (rem_neg), .divisor_zero (divisor_zero),
      .dividend_neg (dividend_neg), .divisor_neg (divisor_neg),
      .init_load (init_load), .reg_we (reg_we), .alu_op (alu_op),
      .shift_left (shift_left), .restore (restore), .q_bit (q_bit),
      .negate_q (negate_q), .busy (busy), .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   always #5 clk = ~clk;

   int nTests = 0, nFail = 0, cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Operation timeline model: offset 0 = INIT, 1..mLen-1 = steps, mLen = DONE
   bit mActive = 0, mIsDiv = 0, mFlag = 0, mDn = 0, mDv = 0;
   int mK = 0, mLen = ITER + 1;
   int mode = 0;  // 0 random step inputs, 1 Booth model, 2 divider model
   logic signed [64:0] P = '0;
   logic [63:0] RQ = '0;
   logic signed [31:0] mcand = 0, mplier = 0;
   logic [31:0] dvd = 0, dvs = 1;

   function automatic int phase();
      if (!mActive)     return 0;
      if (mK == 0)      return 1;
      if (mK == mLen)   return 3;
      return 2;
   endfunction

   function automatic logic [32:0] trialOf(input logic [63:0] rq);
      logic [63:0] sh;
      sh = rq << 1;
      return {1'b0, sh[63:32]} - {1'b0, dvs};
   endfunction

   initial forever begin
      int ph;
      logic signed [31:0] up;
      logic [63:0] sh;
      logic [32:0] tr;
      @(posedge clk);
      ph = phase();
      cyc++;
      if (reset) begin
         mActive = 0; mK = 0; mIsDiv = 0; mFlag = 0; mDn = 0; mDv = 0;
      end else begin
         if (ph == 1) begin
            P  = {32'sd0, mplier, 1'b0};
            RQ = {32'd0, dvd};
         end else if (ph == 2 && !mIsDiv) begin
            up = P[64:33];
            if (P[1:0] == 2'b01) up = up + mcand;
            if (P[1:0] == 2'b10) up = up - mcand;
            P = {up, P[32:0]};
            P = P >>> 1;
         end else if (ph == 2) begin
            tr = trialOf(RQ);
            sh = RQ << 1;
            if (!tr[32]) begin sh[63:32] = tr[31:0]; sh[0] = 1'b1; end
            RQ = sh;
         end
         if (mActive) begin
            if (mK == 0) begin
               mDn = dividend_neg; mDv = divisor_neg;
               mFlag = mIsDiv && divisor_zero;
               mLen = mFlag ? 1 : ITER + 1;
            end
            if (mK == mLen) mActive = 0;
            else            mK++;
         end else if (ctrl_MULT || ctrl_DIV) begin
            mActive = 1; mK = 0; mIsDiv = !ctrl_MULT; mLen = ITER + 1;
         end
      end
      #1;
      if (mode == 1) booth_bits = P[1:0];
      else           booth_bits = 2'($urandom);
      if (mode == 2) begin tr = trialOf(RQ); rem_neg = tr[32]; end
      else           rem_neg = 1'($urandom);
   end

   // Per-cycle compare against the model
   initial forever begin
      int ph;
      logic [1:0] eAlu;
      logic eStep;
      @(negedge clk);
      ph = reset ? 0 : phase();
      eStep = (ph == 2);
      eAlu = 2'b00;
      if (eStep && mIsDiv) eAlu = 2'b10;
      else if (eStep && booth_bits == 2'b01) eAlu = 2'b01;
      else if (eStep && booth_bits == 2'b10) eAlu = 2'b10;
      chk("init_load", init_load, ph == 1);
      chk("reg_we", reg_we, ph == 1 || ph == 2);
      chk("alu_op", alu_op, eAlu);
      chk("shift_left", shift_left, eStep && mIsDiv);
      chk("restore", restore, eStep && mIsDiv && rem_neg);
      chk("q_bit", q_bit, eStep && mIsDiv && !rem_neg);
      chk("busy", busy, ph != 0);
      chk("resultRDY", data_resultRDY, ph == 3);
      chk("exception", data_exception, ph == 3 && mFlag);
      chk("negate_q", negate_q, ph == 3 && mIsDiv && !mFlag && (mDn ^ mDv));
   end

   // Start an op and return at the negedge of its DONE cycle
   task automatic runOp(input bit m, input bit d, input bit noWait, input int pulseAt,
                        output int lat, output int nM, output int nD);
      int c0;
      lat = -1; nM = 0; nD = 0;
      if (!noWait) begin @(posedge clk); #1; end
      ctrl_MULT = m; ctrl_DIV = d;
      c0 = cyc;
      @(posedge clk); #1;
      ctrl_MULT = 0; ctrl_DIV = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (reg_we && !init_load) begin
            if (shift_left) nD++; else nM++;
         end
         ctrl_DIV = (cyc - c0 == pulseAt);
         if (data_resultRDY) begin lat = cyc - c0; break; end
      end
      ctrl_DIV = 0;
   endtask

   initial begin
      int lat, nM, nD, cDone;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_we", reg_we, 0);
      @(posedge clk); #1 reset = 0;

      // 7 x -3 with Booth model
      mode = 1; mcand = 7; mplier = -3;
      runOp(1, 0, 0, -1, lat, nM, nD);
      chk("mul_latency", lat, 34);
      chk("mul_msteps", nM, 32);
      chk("mul_product", P[64:1], 64'hFFFF_FFFF_FFFF_FFEB);

      // divide by zero
      mode = 0; divisor_zero = 1;
      runOp(0, 1, 0, -1, lat, nM, nD);
      chk("dz_latency", lat, 2);
      chk("dz_dsteps", nD, 0);
      chk("dz_exception", data_exception, 1);
      divisor_zero = 0;

      // -20 / 3 with divider model
      mode = 2; dvd = 20; dvs = 3; dividend_neg = 1; divisor_neg = 0;
      runOp(0, 1, 0, -1, lat, nM, nD);
      chk("div_latency", lat, 34);
      chk("div_dsteps", nD, 32);
      chk("div_negate_q", negate_q, 1);
      chk("div_quotient", RQ[31:0], 6);
      chk("div_remainder", RQ[63:32], 2);
      dividend_neg = 0;

      // both starts high, then a DIV pulse at step 10
      mode = 1; mcand = -5; mplier = 13;
      runOp(1, 1, 0, 12, lat, nM, nD);
      chk("both_latency", lat, 34);
      chk("both_msteps", nM, 32);
      chk("both_dsteps", nD, 0);
      chk("both_product", P[64:1], 64'hFFFF_FFFF_FFFF_FFBF);

      // reset at DSTEP step 15
      mode = 0;
      @(posedge clk); #1 ctrl_DIV = 1;
      @(posedge clk); #1 ctrl_DIV = 0;
      repeat (16) @(posedge clk);
      #1;
      chk("pre_rst_dstep", shift_left, 1);
      reset = 1; #1;
      chk("rst_outputs", {init_load, reg_we, alu_op, shift_left, restore, q_bit,
                          negate_q, busy, data_resultRDY, data_exception}, 0);
      @(posedge clk); #1 reset = 0;
      mode = 1; mcand = 9; mplier = 4;
      runOp(1, 0, 1, -1, lat, nM, nD);
      chk("post_rst_latency", lat, 34);
      chk("post_rst_product", P[64:1], 36);

      // back-to-back: start in DONE ignored, start in following IDLE accepted
      mode = 0;
      runOp(1, 0, 0, -1, lat, nM, nD);
      cDone = cyc;
      ctrl_DIV = 1;
      @(posedge clk); #1;
      chk("b2b_idle_gap", busy, 0);
      @(posedge clk); #1 ctrl_DIV = 0;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (data_resultRDY) begin lat = cyc - cDone; break; end
      end
      chk("b2b_spacing", lat, 35);

      // randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         reset        = ($urandom_range(0, 599) == 0);
         ctrl_MULT    = ($urandom_range(0, 9) == 0);
         ctrl_DIV     = ($urandom_range(0, 9) == 0);
         divisor_zero = ($urandom_range(0, 3) == 0);
         dividend_neg = 1'($urandom);
         divisor_neg  = 1'($urandom);
      end
      @(posedge clk); #1;
      reset = 0; ctrl_MULT = 0; ctrl_DIV = 0;
      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
